// File: rtl/block_mult_engine_if.sv
// Memory-bus interface of block_mult_engine: arbiter request/grant plus a
// single-port memory with separate read/write enables.
//   master : the engine (drives request, enables, address, write data)
//   slave  : arbiter + memory (drives grant and read data)
interface block_mult_engine_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned W      = 32
);
  logic              out_request;
  logic              in_grant;
  logic              out_mem_read_en;
  logic              out_mem_write_en;
  logic [ADDR_W-1:0] out_mem_address;
  logic [W-1:0]      out_mem_data;
  logic [W-1:0]      in_mem_data;

  modport master (
    output out_request, out_mem_read_en, out_mem_write_en,
    output out_mem_address, out_mem_data,
    input  in_grant, in_mem_data
  );

  modport slave (
    input  out_request, out_mem_read_en, out_mem_write_en,
    input  out_mem_address, out_mem_data,
    output in_grant, in_mem_data
  );
endinterface

// File: rtl/block_mult_engine.sv
// block_mult_engine: accumulates C = sum_x A_x * B_x over mu pairs of
// SIZE x SIZE blocks held in shared memory, then writes C back row by row.
// Optional feature: define BME_SATURATE_EN to clamp products and sums at
// 2^CELL_W-1 instead of wrapping modulo 2^CELL_W.
// Ports:
//   in_clk, in_reset    clock (rising edge), async active-low reset
//   in_start            job request, held until out_ack
//   in_a/b/c_base       block base addresses, in_mu pair count
//   out_ack             one-cycle pulse when job inputs are captured
//   out_done            one-cycle pulse after the last C row is written
//   bus                 memory/arbiter bus (block_mult_engine_if.master)
module block_mult_engine #(
  parameter int unsigned SIZE   = 4,
  parameter int unsigned CELL_W = 8,
  parameter int unsigned MU_W   = 4,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              in_clk,
  input  logic              in_reset,
  input  logic              in_start,
  input  logic [ADDR_W-1:0] in_a_base,
  input  logic [ADDR_W-1:0] in_b_base,
  input  logic [ADDR_W-1:0] in_c_base,
  input  logic [MU_W-1:0]   in_mu,
  output logic              out_ack,
  output logic              out_done,
  block_mult_engine_if.master bus
);

  localparam int unsigned W     = SIZE * CELL_W;
  localparam int unsigned IDX_W = $clog2(SIZE + 1);
`ifdef BME_SATURATE_EN
  localparam int unsigned PROD_W = 2 * CELL_W;
  localparam logic [CELL_W-1:0] CELL_MAX = '1;
`endif

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, WRITE, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] a_base_q, b_base_q, c_base_q;
  logic [MU_W-1:0]   mu_q, x_q;
  logic [IDX_W-1:0]  idx_q;      // load issue row / compute column / write row
  logic [IDX_W-1:0]  row_q;      // compute row
  logic              rd_pend_q;  // a read was issued last cycle
  logic              rd_b_q;     // that read targets B
  logic [IDX_W-1:0]  rd_row_q;   // row index of that read

  logic [CELL_W-1:0] a_q [SIZE][SIZE];
  logic [CELL_W-1:0] b_q [SIZE][SIZE];
  logic [CELL_W-1:0] c_q [SIZE][SIZE];

  logic              loading, issue, wr_go;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [W-1:0]      wr_data;
  logic [CELL_W-1:0] a_row [SIZE];
  logic [CELL_W-1:0] b_col [SIZE];
  logic [CELL_W-1:0] c_cur, acc;
`ifdef BME_SATURATE_EN
  logic [PROD_W-1:0] prod;
  logic [CELL_W-1:0] prod_cl;
  logic [CELL_W:0]   sum;
`endif

  // Bus-side decode; every data-path output is gated by the grant.
  assign loading = (state == LOAD_A) || (state == LOAD_B);
  assign issue   = loading && (idx_q < IDX_W'(SIZE)) && bus.in_grant;
  assign wr_go   = (state == WRITE) && bus.in_grant;
  assign rd_addr = ((state == LOAD_B) ? b_base_q : a_base_q)
                 + ADDR_W'(x_q) * ADDR_W'(SIZE) + ADDR_W'(idx_q);
  assign wr_addr = c_base_q + ADDR_W'(idx_q);

  assign bus.out_request      = (state == LOAD_A) || (state == LOAD_B) || (state == WRITE);
  assign bus.out_mem_read_en  = issue;
  assign bus.out_mem_write_en = wr_go;
  assign bus.out_mem_address  = issue ? rd_addr : (wr_go ? wr_addr : '0);
  assign bus.out_mem_data     = wr_go ? wr_data : '0;

  // Operand selection for the current C cell and the current write row.
  always_comb begin
    c_cur   = '0;
    wr_data = '0;
    for (int k = 0; k < SIZE; k++) begin
      a_row[k] = '0;
      b_col[k] = '0;
    end
    for (int r = 0; r < SIZE; r++) begin
      for (int k = 0; k < SIZE; k++) begin
        if (row_q == IDX_W'(r)) a_row[k] = a_q[r][k];
        if (idx_q == IDX_W'(r)) begin
          b_col[k] = b_q[k][r];
          wr_data[k*CELL_W +: CELL_W] = c_q[r][k];
        end
        if ((row_q == IDX_W'(r)) && (idx_q == IDX_W'(k))) c_cur = c_q[r][k];
      end
    end
  end

  // Dot product folded onto the existing C cell.
  always_comb begin
    acc = c_cur;
`ifdef BME_SATURATE_EN
    prod    = '0;
    prod_cl = '0;
    sum     = '0;
    for (int k = 0; k < SIZE; k++) begin
      prod    = PROD_W'(a_row[k]) * PROD_W'(b_col[k]);
      prod_cl = (prod > PROD_W'(CELL_MAX)) ? CELL_MAX : prod[CELL_W-1:0];
      sum     = {1'b0, acc} + {1'b0, prod_cl};
      acc     = sum[CELL_W] ? CELL_MAX : sum[CELL_W-1:0];
    end
`else
    for (int k = 0; k < SIZE; k++) begin
      acc = acc + a_row[k] * b_col[k];
    end
`endif
  end

  // Control FSM, storage and registered handshake pulses.
  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state     <= IDLE;
      a_base_q  <= '0;
      b_base_q  <= '0;
      c_base_q  <= '0;
      mu_q      <= '0;
      x_q       <= '0;
      idx_q     <= '0;
      row_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_b_q    <= 1'b0;
      rd_row_q  <= '0;
      out_ack   <= 1'b0;
      out_done  <= 1'b0;
      for (int r = 0; r < SIZE; r++) begin
        for (int k = 0; k < SIZE; k++) begin
          a_q[r][k] <= '0;
          b_q[r][k] <= '0;
          c_q[r][k] <= '0;
        end
      end
    end else begin
      out_ack   <= 1'b0;
      out_done  <= 1'b0;
      rd_pend_q <= issue;
      rd_b_q    <= (state == LOAD_B);
      rd_row_q  <= idx_q;

      // Read data returns one cycle after issue, regardless of grant.
      if (rd_pend_q) begin
        for (int r = 0; r < SIZE; r++) begin
          if (rd_row_q == IDX_W'(r)) begin
            for (int k = 0; k < SIZE; k++) begin
              if (rd_b_q) b_q[r][k] <= bus.in_mem_data[k*CELL_W +: CELL_W];
              else        a_q[r][k] <= bus.in_mem_data[k*CELL_W +: CELL_W];
            end
          end
        end
      end

      case (state)
        IDLE: begin
          if (in_start) begin
            a_base_q <= in_a_base;
            b_base_q <= in_b_base;
            c_base_q <= in_c_base;
            mu_q     <= in_mu;
            x_q      <= '0;
            idx_q    <= '0;
            row_q    <= '0;
            out_ack  <= 1'b1;
            for (int r = 0; r < SIZE; r++) begin
              for (int k = 0; k < SIZE; k++) c_q[r][k] <= '0;
            end
            state <= (in_mu == '0) ? WRITE : LOAD_A;
          end
        end
        LOAD_A, LOAD_B: begin
          if (issue) begin
            idx_q <= idx_q + IDX_W'(1);
          end else if (idx_q == IDX_W'(SIZE)) begin
            // Last row is being captured on this edge.
            idx_q <= '0;
            state <= (state == LOAD_A) ? LOAD_B : COMPUTE;
          end
        end
        COMPUTE: begin
          for (int r = 0; r < SIZE; r++) begin
            for (int k = 0; k < SIZE; k++) begin
              if ((row_q == IDX_W'(r)) && (idx_q == IDX_W'(k))) c_q[r][k] <= acc;
            end
          end
          if (idx_q == IDX_W'(SIZE - 1)) begin
            idx_q <= '0;
            if (row_q == IDX_W'(SIZE - 1)) begin
              row_q <= '0;
              if ((MU_W + 1)'(x_q) + (MU_W + 1)'(1) < (MU_W + 1)'(mu_q)) begin
                x_q   <= x_q + MU_W'(1);
                state <= LOAD_A;
              end else begin
                state <= WRITE;
              end
            end else begin
              row_q <= row_q + IDX_W'(1);
            end
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        WRITE: begin
          if (bus.in_grant) begin
            if (idx_q == IDX_W'(SIZE - 1)) begin
              idx_q    <= '0;
              out_done <= 1'b1;
              state    <= DONE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/block_mult_engine.md
BLOCK_MULT_ENGINE -- requirements
Module: block_mult_engine

Interface
REQ-001 SHALL have parameter SIZE, default 4: block dimension, SIZE x SIZE cells.
REQ-002 SHALL have parameter CELL_W, default 8: cell width in bits; row width W = SIZE*CELL_W.
REQ-003 SHALL have parameter MU_W, default 4: width of the block-count input.
REQ-004 SHALL have parameter ADDR_W, default 10: memory address width.
REQ-005 SHALL have port in_clk, input, 1: clock, rising edge.
REQ-006 SHALL have port in_reset, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port in_start, input, 1: job request, level until acknowledged.
REQ-008 SHALL have ports in_a_base, in_b_base, in_c_base, input, ADDR_W each: block base addresses.
REQ-009 SHALL have port in_mu, input, MU_W: number of A/B block pairs to accumulate.
REQ-010 SHALL have port out_ack, input-latch acknowledge, output, 1: one-cycle pulse when job inputs are captured.
REQ-011 SHALL have port out_done, output, 1: one-cycle pulse after the last C row is written.
REQ-012 SHALL have port out_request, output, 1: memory bus request to arbiter.
REQ-013 SHALL have port in_grant, input, 1: arbiter grant.
REQ-014 SHALL have ports out_mem_read_en and out_mem_write_en, output, 1 each.
REQ-015 SHALL have ports out_mem_address (output, ADDR_W), out_mem_data (output, W) and in_mem_data (input, W); row cell k occupies bits [k*CELL_W +: CELL_W].

Function
REQ-016 SHALL compute C = sum over x=0..mu-1 of A_x * B_x, where A_x row r is at a_base + x*SIZE + r, B_x row r at b_base + x*SIZE + r, and C row r is written to c_base + r.
REQ-017 SHALL use states IDLE, LOAD_A, LOAD_B, COMPUTE, WRITE, DONE.
REQ-018 IDLE: on in_start=1, SHALL capture bases and mu, pulse out_ack, clear the C accumulator, and go to LOAD_A (or WRITE if mu=0).
REQ-019 SHALL assert out_request throughout LOAD_A, LOAD_B and WRITE, and deassert it in IDLE, COMPUTE and DONE.
REQ-020 SHALL drive out_mem_read_en, out_mem_write_en, out_mem_address and out_mem_data to zero whenever in_grant=0; no tristate outputs.
REQ-021 Reads: read_en at cycle t with grant=1 SHALL sample in_mem_data at t+1; SIZE row reads per LOAD state, one per granted cycle.
REQ-022 Grant loss mid-load SHALL stall the row counter and hold the address; the in-flight read SHALL still be captured at t+1.
REQ-023 LOAD_A then LOAD_B SHALL occupy the bus at least SIZE+1 cycles each, including the final data capture.
REQ-024 COMPUTE SHALL produce one C cell per cycle in row-major order, C[r][c] += sum_k A[r][k]*B[k][c], taking SIZE*SIZE cycles.
REQ-025 Arithmetic: products and sums SHALL be truncated modulo 2^CELL_W, unsigned.
REQ-026 After COMPUTE: if x < mu-1, SHALL increment x and go to LOAD_A; otherwise SHALL go to WRITE.
REQ-027 WRITE SHALL assert write_en with address and data in the same granted cycle, one row per cycle, SIZE rows, stalling on grant=0.
REQ-028 DONE SHALL pulse out_done for one cycle, return to IDLE, and ignore in_start during that cycle.
REQ-029 mu=0 SHALL write SIZE all-zero rows.
REQ-030 in_start asserted while busy SHALL be ignored until IDLE.

Reset
REQ-031 in_reset=0 SHALL immediately force IDLE and zero all outputs, counters and A/B/C storage, including mid-job.
REQ-032 A job interrupted by reset SHALL NOT produce out_done, and no partial write SHALL be issued after reset.

Configuration
REQ-033 With BME_SATURATE_EN defined, each accumulation SHALL clamp at 2^CELL_W-1, and products exceeding the range SHALL also clamp; without it, REQ-025 wrap SHALL apply.

Verification
REQ-034 SIZE=2, CELL_W=8, mu=1, A=[[1,2],[3,4]], B=[[5,6],[7,8]], grant always 1 -> writes [19,22] then [43,50] at c_base and c_base+1, then one out_done.
REQ-035 Same job with mu=2, second pair identical -> C=[[38,44],[86,100]].
REQ-036 Grant toggled 1,0,1,0 during LOAD_A -> identical result; no duplicate or skipped row addresses; outputs zero while grant=0.
REQ-037 mu=0 -> two zero-row writes then out_done; A=[[200,0],[0,0]], B=[[2,0],[0,0]] -> C[0][0]=144 (wrap), or 255 with BME_SATURATE_EN.
REQ-038 in_reset low mid-COMPUTE -> outputs zero within the same cycle, no out_done; a fresh job afterwards matches REQ-034.
